// File: rtl/tabla_verdad_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : tabla_verdad_pkg
//  Purpose : Shared types and constants for the exhaustive truth-table
//            equivalence checker (tabla_verdad_cmp and barrido_contador).
//  Contents: state_t      - checker FSM state encoding (IDLE/WAIT/SAMPLE/DONE)
//            c_SETTLE_W   - width of the settle down-counter (SETTLE <= 15)
//  Revision: 1.0 - initial release
// ============================================================================
package tabla_verdad_pkg;

  // Enough bits for the largest supported settle time (15 cycles).
  localparam int c_SETTLE_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage : tabla_verdad_pkg
`default_nettype wire

// File: rtl/tabla_verdad_cmp_barrido_contador.sv
`default_nettype none
// ============================================================================
//  Module  : barrido_contador
//  Purpose : Sweep sequencer for the truth-table checker. Holds the current
//            input vector and the settle down-counter that paces sampling.
//  Ports   : clk      in  1     rising-edge clock
//            reset    in  1     synchronous active-low reset
//            load     in  1     restart sweep: vector 0, settle reloaded
//            advance  in  1     step to next vector, settle reloaded
//            run      in  1     settle counter decrements while high
//            vec_out  out N_IN  current input vector
//            strike   out 1     settle time expires this cycle (sample next)
//            last     out 1     current vector is all ones
//  Revision: 1.0 - initial release
// ============================================================================
module barrido_contador
  import tabla_verdad_pkg::*;
#(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            advance,
  input  logic            run,
  output logic [N_IN-1:0] vec_out,
  output logic            strike,
  output logic            last
);

  localparam logic [c_SETTLE_W-1:0] c_SETTLE_INIT = c_SETTLE_W'(SETTLE);
  localparam logic [c_SETTLE_W-1:0] c_SETTLE_ONE  = c_SETTLE_W'(1);

  logic [N_IN-1:0]       r_vec;
  logic [c_SETTLE_W-1:0] r_settle;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_vec    <= '0;
      r_settle <= '0;
    end else if (load) begin
      r_vec    <= '0;
      r_settle <= c_SETTLE_INIT;
    end else if (advance) begin
      r_vec    <= r_vec + 1'b1;
      r_settle <= c_SETTLE_INIT;
    end else if (run && (r_settle != '0)) begin
      r_settle <= r_settle - 1'b1;
    end
  end

  // The counter holds SETTLE..1 across the WAIT cycles; reaching 1 means
  // this is the final wait cycle and the next one samples.
  assign strike  = run && (r_settle == c_SETTLE_ONE);
  assign last    = &r_vec;
  assign vec_out = r_vec;

endmodule : barrido_contador
`default_nettype wire

// File: rtl/tabla_verdad_cmp.sv
`default_nettype none
// ============================================================================
//  Module  : tabla_verdad_cmp
//  Purpose : Exhaustive-sweep equivalence checker. Drives every input vector
//            0..2^N_IN-1 to two external implementations of the same
//            function, waits SETTLE cycles, compares their N_OUT outputs and
//            accumulates pass/fail statistics.
//  Ports   : clk              in  1       rising-edge clock
//            reset            in  1       synchronous active-low reset
//            start            in  1       begin a sweep (ignored while busy)
//            vec_out          out N_IN    vector driven to both functions
//            a_in             in  N_OUT   canonical implementation outputs
//            b_in             in  N_OUT   simplified implementation outputs
//            busy             out 1       sweep in progress
//            done             out 1       sweep finished (held)
//            pass             out 1       done with zero mismatches
//            err_count        out N_IN+1  vectors with any channel mismatch
//            first_err_valid  out 1       a mismatch has been recorded
//            first_err_vec    out N_IN    vector of the first mismatch
//            ch_fail          out N_OUT   sticky per-channel mismatch mask
//  Options : STOP_ON_ERR_EN - when defined, the first mismatching vector
//            ends the sweep immediately.
//  Revision: 1.0 - initial release
// ============================================================================
module tabla_verdad_cmp
  import tabla_verdad_pkg::*;
#(
  parameter int N_IN   = 4,
  parameter int N_OUT  = 3,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [N_IN-1:0]  vec_out,
  input  logic [N_OUT-1:0] a_in,
  input  logic [N_OUT-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [N_IN:0]    err_count,
  output logic             first_err_valid,
  output logic [N_IN-1:0]  first_err_vec,
  output logic [N_OUT-1:0] ch_fail
);

  // After loading or advancing, either settle first or sample directly.
  localparam state_t c_AFTER_STEP = (SETTLE == 0) ? SAMPLE : WAIT;

  state_t r_state;
  state_t w_state_n;

  logic w_load;
  logic w_advance;
  logic w_run;
  logic w_strike;
  logic w_last;

  logic [N_OUT-1:0] w_diff;
  logic             w_mismatch;
  logic [N_IN:0]    w_err_next;

  logic             r_pass;
  logic [N_IN:0]    r_err_count;
  logic             r_first_err_valid;
  logic [N_IN-1:0]  r_first_err_vec;
  logic [N_OUT-1:0] r_ch_fail;

  barrido_contador #(
    .N_IN   (N_IN),
    .SETTLE (SETTLE)
  ) u_barrido (
    .clk     (clk),
    .reset   (reset),
    .load    (w_load),
    .advance (w_advance),
    .run     (w_run),
    .vec_out (vec_out),
    .strike  (w_strike),
    .last    (w_last)
  );

  assign w_diff     = a_in ^ b_in;
  assign w_mismatch = (w_diff != '0);
  // err_count is N_IN+1 bits and counts at most 2^N_IN vectors: no wrap.
  assign w_err_next = r_err_count + {{N_IN{1'b0}}, w_mismatch};

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and sequencer controls
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_n = r_state;
    w_load    = 1'b0;
    w_advance = 1'b0;
    w_run     = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_load    = 1'b1;
          w_state_n = c_AFTER_STEP;
        end
      end
      WAIT: begin
        w_run = 1'b1;
        if (w_strike) begin
          w_state_n = SAMPLE;
        end
      end
      SAMPLE: begin
`ifdef STOP_ON_ERR_EN
        if (w_mismatch || w_last) begin
          w_state_n = DONE;
        end else begin
          w_advance = 1'b1;
          w_state_n = c_AFTER_STEP;
        end
`else
        if (w_last) begin
          w_state_n = DONE;
        end else begin
          w_advance = 1'b1;
          w_state_n = c_AFTER_STEP;
        end
`endif
      end
      default: begin
        w_state_n = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Statistics. Cleared when a sweep is accepted; updated only in SAMPLE.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pass            <= 1'b0;
      r_err_count       <= '0;
      r_first_err_valid <= 1'b0;
      r_first_err_vec   <= '0;
      r_ch_fail         <= '0;
    end else if (w_load) begin
      r_pass            <= 1'b0;
      r_err_count       <= '0;
      r_first_err_valid <= 1'b0;
      r_first_err_vec   <= '0;
      r_ch_fail         <= '0;
    end else if (r_state == SAMPLE) begin
      r_ch_fail   <= r_ch_fail | w_diff;
      r_err_count <= w_err_next;
      if (w_mismatch && !r_first_err_valid) begin
        r_first_err_valid <= 1'b1;
        r_first_err_vec   <= vec_out;
      end
      // pass becomes visible in the same cycle as done.
      if (w_state_n == DONE) begin
        r_pass <= (w_err_next == '0);
      end
    end
  end

  assign busy            = (r_state == WAIT) || (r_state == SAMPLE);
  assign done            = (r_state == DONE);
  assign pass            = r_pass;
  assign err_count       = r_err_count;
  assign first_err_valid = r_first_err_valid;
  assign first_err_vec   = r_first_err_vec;
  assign ch_fail         = r_ch_fail;

endmodule : tabla_verdad_cmp
`default_nettype wire

// File: tb/tb_tabla_verdad_cmp.sv
`default_nettype none
// ============================================================================
//  Module  : tb_tabla_verdad_cmp
//  Purpose : Directed self-checking bench for tabla_verdad_cmp with
//            N_IN=4, N_OUT=3, SETTLE=1. The canonical function is a small
//            combinational model; the simplified one is the same function
//            with a mode-selected fault injected.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_tabla_verdad_cmp;

  localparam int N_IN   = 4;
  localparam int N_OUT  = 3;
  localparam int SETTLE = 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [N_IN-1:0]  vec_out;
  logic [N_OUT-1:0] a_in;
  logic [N_OUT-1:0] b_in;
  logic             busy;
  logic             done;
  logic             pass;
  logic [N_IN:0]    err_count;
  logic             first_err_valid;
  logic [N_IN-1:0]  first_err_vec;
  logic [N_OUT-1:0] ch_fail;

  int mode = 0;
  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tabla_verdad_cmp #(
    .N_IN   (N_IN),
    .N_OUT  (N_OUT),
    .SETTLE (SETTLE)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .vec_out         (vec_out),
    .a_in            (a_in),
    .b_in            (b_in),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .err_count       (err_count),
    .first_err_valid (first_err_valid),
    .first_err_vec   (first_err_vec),
    .ch_fail         (ch_fail)
  );

  // Canonical function and fault-injected "simplified" version.
  always_comb begin
    a_in = {vec_out[3] ^ vec_out[0], vec_out[2] & vec_out[1], vec_out[1] | vec_out[0]};
    b_in = a_in;
    case (mode)
      1: if (vec_out == 4'd5) b_in = a_in ^ 3'b010;
      2: b_in = a_in ^ 3'b001;
      3: if (vec_out == 4'd9) b_in = a_in ^ 3'b100;
      default: b_in = a_in;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start across one rising edge (driven and released on falling edges).
  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Called right after pulse_start: one edge has passed. Checks done is
  // still low after edge total_edges-1 and high after total_edges.
  task automatic expect_done_at(input string tag, input int total_edges);
    repeat (total_edges - 2) @(negedge clk);
    chk({tag, "_not_yet_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_busy_before"},  {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    // ---------------- reset state ----------------
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_vec",   {28'd0, vec_out}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_done",  {31'd0, done}, 32'd0);
    chk("rst_pass",  {31'd0, pass}, 32'd0);
    chk("rst_err",   {27'd0, err_count}, 32'd0);
    chk("rst_fev",   {31'd0, first_err_valid}, 32'd0);
    chk("rst_chf",   {29'd0, ch_fail}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // ---------------- matching functions ----------------
    mode = 0;
    pulse_start();
    chk("m0_vec0",  {28'd0, vec_out}, 32'd0);
    chk("m0_busy",  {31'd0, busy}, 32'd1);
    expect_done_at("m0", 33);
    chk("m0_pass",  {31'd0, pass}, 32'd1);
    chk("m0_err",   {27'd0, err_count}, 32'd0);
    chk("m0_chf",   {29'd0, ch_fail}, 32'd0);
    chk("m0_fev",   {31'd0, first_err_valid}, 32'd0);
    chk("m0_vecend", {28'd0, vec_out}, 32'd15);

    // ---------------- single fault at vector 5, bit 1 ----------------
    mode = 1;
    pulse_start();
    expect_done_at("m1", 33);
    chk("m1_err",  {27'd0, err_count}, 32'd1);
    chk("m1_fev",  {31'd0, first_err_valid}, 32'd1);
    chk("m1_fevec", {28'd0, first_err_vec}, 32'd5);
    chk("m1_chf",  {29'd0, ch_fail}, 32'b010);
    chk("m1_pass", {31'd0, pass}, 32'd0);

    // ---------------- bit 0 inverted everywhere ----------------
    mode = 2;
    pulse_start();
    expect_done_at("m2", 33);
    chk("m2_err",  {27'd0, err_count}, 32'd16);
    chk("m2_fev",  {31'd0, first_err_valid}, 32'd1);
    chk("m2_fevec", {28'd0, first_err_vec}, 32'd0);
    chk("m2_chf",  {29'd0, ch_fail}, 32'b001);
    chk("m2_pass", {31'd0, pass}, 32'd0);

    // ---------------- restart from DONE after failure ----------------
    mode = 0;
    pulse_start();
    chk("rs_err_clr", {27'd0, err_count}, 32'd0);
    chk("rs_chf_clr", {29'd0, ch_fail}, 32'd0);
    chk("rs_fev_clr", {31'd0, first_err_valid}, 32'd0);
    chk("rs_done_clr", {31'd0, done}, 32'd0);
    chk("rs_vec0",    {28'd0, vec_out}, 32'd0);
    expect_done_at("rs", 33);
    chk("rs_pass", {31'd0, pass}, 32'd1);

    // ---------------- reset mid-sweep, then ignored starts ----------------
    mode = 2;
    pulse_start();
    begin
      int guard = 0;
      while (vec_out != 4'd7 && guard < 100) begin
        @(negedge clk);
        guard++;
      end
      chk("ab_reach7", {28'd0, vec_out}, 32'd7);
    end
    reset = 1'b0;
    @(negedge clk);
    chk("ab_vec",  {28'd0, vec_out}, 32'd0);
    chk("ab_busy", {31'd0, busy}, 32'd0);
    chk("ab_done", {31'd0, done}, 32'd0);
    chk("ab_err",  {27'd0, err_count}, 32'd0);
    chk("ab_fev",  {31'd0, first_err_valid}, 32'd0);
    chk("ab_chf",  {29'd0, ch_fail}, 32'd0);
    reset = 1'b1;
    mode = 0;
    @(negedge clk);
    pulse_start();
    // Extra starts during busy, each across one edge (edges 3,6,9,12 overall).
    for (int i = 0; i < 4; i++) begin
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      @(negedge clk);
    end
    chk("ab_busy_mid", {31'd0, busy}, 32'd1);
    // 1 + 12 edges have elapsed since the accepted start edge.
    repeat (31 - 12) @(negedge clk);
    chk("ab2_not_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    chk("ab2_done", {31'd0, done}, 32'd1);
    chk("ab2_pass", {31'd0, pass}, 32'd1);

    // ---------------- mismatch only at vector 9 ----------------
    mode = 3;
    pulse_start();
`ifdef STOP_ON_ERR_EN
    expect_done_at("m3", 21);
    chk("m3_vec",  {28'd0, vec_out}, 32'd9);
    chk("m3_chf",  {29'd0, ch_fail}, 32'b100);
`else
    expect_done_at("m3", 33);
    chk("m3_vec",  {28'd0, vec_out}, 32'd15);
    chk("m3_chf",  {29'd0, ch_fail}, 32'b100);
`endif
    chk("m3_err",   {27'd0, err_count}, 32'd1);
    chk("m3_fevec", {28'd0, first_err_vec}, 32'd9);
    chk("m3_pass",  {31'd0, pass}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_tabla_verdad_cmp
`default_nettype wire

// File: doc/tabla_verdad_cmp.md
Name: tabla_verdad_cmp

Overview:
Hardware exhaustive-sweep equivalence checker for combinational boolean functions.
- Drives every input vector 0 .. 2^N_IN-1 onto two externally wired implementations of the same N_OUT-channel function: canonical form (a) and simplified form (b).
- Waits a settle time, compares outputs, and accumulates pass/fail statistics.
- Sits beside the exercise logic blocks as the synthesizable successor to software-driven truth-table sweeps.

Parameters:
N_IN, 4, number of function inputs; sweep length 2^N_IN vectors (1..16).
N_OUT, 3, number of output channels compared in parallel (1..32).
SETTLE, 1, wait cycles between applying a vector and sampling (0..15).

Ports:
clk  in  1  clock; all logic rising-edge.
reset  in  1  synchronous, active-low reset; reset==0 at a rising edge resets the block.
start  in  1  single-cycle request to begin a sweep.
vec_out  out  N_IN  current input vector driven to both implementations.
a_in  in  N_OUT  outputs of the canonical implementation.
b_in  in  N_OUT  outputs of the simplified implementation.
busy  out  1  sweep in progress.
done  out  1  sweep finished; level held until the next start or reset.
pass  out  1  done and zero mismatches.
err_count  out  N_IN+1  number of vectors with any channel mismatch.
first_err_valid  out  1  at least one mismatch recorded.
first_err_vec  out  N_IN  vector of the first mismatch.
ch_fail  out  N_OUT  sticky per-channel mismatch mask.

Behaviour:
- Reset: every output is 0; FSM enters IDLE. Reset has priority over start.
- Reset mid-sweep aborts the sweep; no partial result is kept.
- FSM states: IDLE, WAIT, SAMPLE, DONE.
- IDLE/DONE + start: the next cycle enters WAIT, or SAMPLE if SETTLE=0.
  - vec_out=0, busy=1, done=0, pass=0.
  - err_count, first_err_*, and ch_fail are cleared.
- WAIT: holds vec_out for exactly SETTLE cycles, then goes to SAMPLE.
- SAMPLE (1 cycle): computes diff = a_in ^ b_in.
  - ch_fail |= diff.
  - If diff != 0: err_count += 1.
  - If diff != 0 and first_err_valid==0: first_err_vec = vec_out and first_err_valid = 1.
  - If vec_out is all-ones: go to DONE. Otherwise vec_out += 1 and go to WAIT/SAMPLE.
- Timing: with start sampled in cycle t, vector k is sampled in cycle t+1+k*(SETTLE+1)+SETTLE.
- Completion: done=1 and busy=0 from cycle t+2^N_IN*(SETTLE+1)+1.
  - pass is registered alongside done: pass = (err_count_final==0).
- start while busy is ignored.
- err_count is wide enough for 2^N_IN and never wraps.
- vec_out keeps its last value in DONE and returns to 0 only on start or reset.
- a_in and b_in are only sampled in SAMPLE; their value in other states is don't-care.

Optional Feature:
Macro STOP_ON_ERR_EN.
- Defined: the first mismatching SAMPLE goes straight to DONE. err_count=1, pass=0, and ch_fail holds only that vector's diff.
- Undefined: the full sweep always runs to the last vector.

Decomposition:
- Package tabla_verdad_pkg: FSM state typedef (IDLE, WAIT, SAMPLE, DONE) and a localparam for the maximum SETTLE width.
- One natural sub-module, barrido_contador:
  - Contains the vector counter plus settle down-counter.
  - Outputs vec_out, a sample strike pulse, and a last flag.
  - The top keeps the FSM and statistics.

Test Plan:
All cases use N_IN=4, N_OUT=3, SETTLE=1.
- b_in wired equal to a_in; start in cycle t -> done=1 at t+33; pass=1; err_count=0; ch_fail=000; first_err_valid=0.
- b_in = a_in except bit1 inverted when vec_out==5 -> err_count=1; first_err_vec=5; ch_fail=3'b010; pass=0.
- b_in[0] = ~a_in[0] for all vectors -> err_count=16; first_err_vec=0; ch_fail=3'b001.
- reset=0 while vec_out==7, then start pulsed repeatedly during the following busy period -> one cycle after reset all outputs are 0; extra starts are ignored; done at t'+33 from the accepted start.
- start from DONE after a failing sweep, with matching functions -> statistics cleared on entry; second sweep gives pass=1.
- STOP_ON_ERR_EN defined, mismatch only at vec 9 -> sample at t+20; done=1 at t+21; vec_out=9; err_count=1.
